// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, one-hot receiver/transmitter states and baud arithmetic.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } uart_state_e;

    function automatic int baud_width(input int clock_speed, input int baud_rate);
        return clock_speed / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver, bundled for the consumer connection.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 rx_busy;

    // master drives the line and consumes bytes; slave is the receiver itself
    modport master (
        output rx,
        input  rx_data, rx_valid, frame_err, rx_busy
    );

    modport slave (
        input  rx,
        output rx_data, rx_valid, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the async rx line plus a one-clock-delayed copy for falling-edge detection.
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic meta_q, meta_d;
    logic rx_s_q, rx_s_d;
    logic rx_dly_q, rx_dly_d;

    always_comb begin
        meta_d   = rx;
        rx_s_d   = meta_q;
        rx_dly_d = rx_s_q;
    end

    // Reset to the idle line level so leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= 1'b1;
            rx_s_q   <= 1'b1;
            rx_dly_q <= 1'b1;
        end else begin
            meta_q   <= meta_d;
            rx_s_q   <= rx_s_d;
            rx_dly_q <= rx_dly_d;
        end
    end

    assign rx_s = rx_s_q;
    assign fall = rx_dly_q & ~rx_s_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB-first, 1 stop; mid-bit sampling, byte and error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE      = 115_200,
    parameter int CLOCK_SPEED    = 50_000_000,
    parameter bit INVERT_PAYLOAD = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    uart_rx_if.slave bus
);
    localparam int BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
    localparam int HALF_WIDTH = BAUD_WIDTH / 2;
    localparam int CNT_W      = $clog2(BAUD_WIDTH);
    localparam int IDX_W      = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;
    logic fall;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus.rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                // A start bit that is high again at its middle was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
                if (cnt_q == BAUD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = INVERT_PAYLOAD ? ~shift_q : shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on the line with payload bits inverted.
module tb_uart_rx;
    localparam int BW = 434;
    localparam int HW = 217;
    localparam int STROBE_LAT = 3 + HW + 9 * BW;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    int         n_valid;
    int         n_ferr;
    int         n_both;
    int         last_valid_cyc;
    int         start_cyc;
    logic [7:0] got_q[$];

    uart_rx_if u_if ();

    uart_rx #(
        .BAUD_RATE      (115_200),
        .CLOCK_SPEED    (50_000_000),
        .INVERT_PAYLOAD (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.rx_valid === 1'b1) begin
            n_valid        = n_valid + 1;
            last_valid_cyc = cyc;
            got_q.push_back(u_if.rx_data);
        end
        if (u_if.frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (u_if.rx_valid === 1'b1 && u_if.frame_err === 1'b1) n_both = n_both + 1;
    end

    task automatic clear_mon();
        n_valid = 0;
        n_ferr  = 0;
        n_both  = 0;
        got_q.delete();
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
        start_cyc = cyc;
        u_if.rx = 1'b0;
        hold(period);
        for (int k = 0; k < 8; k++) begin
            u_if.rx = ~b[k];
            hold(period);
        end
        u_if.rx = stop_bit;
        hold(period);
        u_if.rx = 1'b1;
    endtask

    task automatic test_reset();
        u_if.rx = 1'b1;
        rst_n   = 1'b0;
        hold(3);
        total++;
        if (u_if.rx_data !== 8'h00) begin
            bad++; $display("FAIL reset_rx_data got=%h want=00", u_if.rx_data);
        end
        total++;
        if ({u_if.rx_valid, u_if.frame_err, u_if.rx_busy} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {u_if.rx_valid, u_if.frame_err, u_if.rx_busy});
        end
        rst_n = 1'b1;
        hold(5);
    endtask

    task automatic test_loopback();
        clear_mon();
        send_frame(8'hA5, BW, 1'b1);
        hold(50);
        total++;
        if (n_valid !== 1) begin bad++; $display("FAIL a5_count got=%0d want=1", n_valid); end
        else begin
            total++;
            if (got_q[0] !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", got_q[0]); end
            total++;
            if (last_valid_cyc - start_cyc !== STROBE_LAT) begin
                bad++; $display("FAIL a5_latency got=%0d want=%0d", last_valid_cyc - start_cyc, STROBE_LAT);
            end
        end
        total++;
        if (n_ferr !== 0) begin bad++; $display("FAIL a5_ferr got=%0d want=0", n_ferr); end
        total++;
        if (u_if.rx_data !== 8'hA5) begin bad++; $display("FAIL a5_hold got=%h want=a5", u_if.rx_data); end
    endtask

    task automatic test_break();
        clear_mon();
        u_if.rx = 1'b0;
        hold(100);
        u_if.rx = 1'b1;
        hold(HW + 2 - 100);
        total++;
        if (u_if.rx_busy !== 1'b1) begin bad++; $display("FAIL break_busy_hi got=%b want=1", u_if.rx_busy); end
        hold(1);
        total++;
        if (u_if.rx_busy !== 1'b0) begin bad++; $display("FAIL break_busy_lo got=%b want=0", u_if.rx_busy); end
        hold(BW);
        total++;
        if (n_valid + n_ferr !== 0) begin bad++; $display("FAIL break_strobe got=%0d want=0", n_valid + n_ferr); end
        send_frame(8'h3C, BW, 1'b1);
        hold(50);
        total++;
        if (n_valid !== 1 || got_q.size() != 1) begin bad++; $display("FAIL 3c_count got=%0d want=1", n_valid); end
        else begin
            total++;
            if (got_q[0] !== 8'h3C) begin bad++; $display("FAIL 3c_data got=%h want=3c", got_q[0]); end
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'h5A, BW, 1'b0);
        hold(50);
        total++;
        if (n_ferr !== 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", n_ferr); end
        total++;
        if (n_valid !== 0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", n_valid); end
        total++;
        if (u_if.rx_data !== 8'h3C) begin bad++; $display("FAIL ferr_hold got=%h want=3c", u_if.rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h81;
        clear_mon();
        for (int i = 0; i < 3; i++) send_frame(exp[i], BW, 1'b1);
        hold(50);
        total++;
        if (n_valid !== 3 || got_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", n_valid); end
        else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_q[i] !== exp[i]) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", i, got_q[i], exp[i]); end
            end
        end
        total++;
        if (n_ferr !== 0) begin bad++; $display("FAIL b2b_ferr got=%0d want=0", n_ferr); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h0F;
        clear_mon();
        u_if.rx = 1'b0;
        hold(BW);
        for (int k = 0; k < 4; k++) begin
            u_if.rx = ~b[k];
            hold(BW);
        end
        u_if.rx = ~b[4];
        hold(BW / 2);
        rst_n = 1'b0;
        hold(1);
        rst_n = 1'b1;
        total++;
        if ({u_if.rx_data, u_if.rx_valid, u_if.frame_err, u_if.rx_busy} !== 11'd0) begin
            bad++; $display("FAIL midrst_outputs got=%h/%b%b%b want=00/000", u_if.rx_data,
                            u_if.rx_valid, u_if.frame_err, u_if.rx_busy);
        end
        hold(BW * 5);
        total++;
        if (n_valid + n_ferr !== 0) begin bad++; $display("FAIL midrst_strobe got=%0d want=0", n_valid + n_ferr); end
        send_frame(8'h12, BW, 1'b1);
        hold(50);
        total++;
        if (n_valid !== 1 || got_q.size() != 1) begin bad++; $display("FAIL 12_count got=%0d want=1", n_valid); end
        else begin
            total++;
            if (got_q[0] !== 8'h12) begin bad++; $display("FAIL 12_data got=%h want=12", got_q[0]); end
        end
    endtask

    task automatic test_skew();
        int per [2];
        per[0] = 425; per[1] = 443;
        for (int i = 0; i < 2; i++) begin
            clear_mon();
            send_frame(8'hC3, per[i], 1'b1);
            hold(100);
            total++;
            if (n_valid !== 1 || got_q.size() != 1 || n_ferr !== 0) begin
                bad++; $display("FAIL skew%0d_count got=%0d/%0d want=1/0", per[i], n_valid, n_ferr);
            end else begin
                total++;
                if (got_q[0] !== 8'hC3) begin bad++; $display("FAIL skew%0d_data got=%h want=c3", per[i], got_q[0]); end
            end
            total++;
            if (n_both !== 0) begin bad++; $display("FAIL skew%0d_both got=%0d want=0", per[i], n_both); end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        u_if.rx = 1'b1;
        rst_n   = 1'b1;
        clear_mon();
        test_reset();
        test_loopback();
        test_break();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_skew();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
